// File: rtl/change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : change_dispenser                                             |
// | Description : Pays out a latched balance as a greedy sequence of coins /   |
// |               notes over a valid/ack handshake. One denomination is        |
// |               issued at a time, largest first. Reports done, coin count    |
// |               and error status.                                            |
// | Ports       : clock, reset_n    - clock, async active-low reset            |
// |               start, amount     - job request and cents to return          |
// |               coin_ack          - dispenser accepted current coin          |
// |               coin_valid/code   - current coin offer (code 0..6)           |
// |               busy, done        - job in progress / end-of-job pulse       |
// |               err_code          - 00 ok, 01 unpayable residue, 10 jam      |
// |               coin_count        - coins issued this job (saturating)       |
// |               remaining         - cents still owed                         |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module change_dispenser #(
    parameter int AMOUNT_W    = 14,
    parameter int GAP_CYCLES  = 4,
    parameter int ACK_TIMEOUT = 1000000,
    parameter int TO_W        = 20
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                start,
    input  logic [AMOUNT_W-1:0] amount,
    input  logic                coin_ack,
    output logic                coin_valid,
    output logic [2:0]          coin_code,
    output logic                busy,
    output logic                done,
    output logic [1:0]          err_code,
    output logic [4:0]          coin_count,
    output logic [AMOUNT_W-1:0] remaining
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_SELECT = 3'd1;
    localparam logic [2:0] c_ISSUE  = 3'd2;
    localparam logic [2:0] c_GAP    = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;
    localparam logic [2:0] c_ERROR  = 3'd5;

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] c_GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [TO_W-1:0]  c_TO_LAST  = TO_W'(ACK_TIMEOUT - 1);

    logic [2:0]          r_state,      w_state;
    logic [AMOUNT_W-1:0] r_remaining,  w_remaining;
    logic [4:0]          r_coin_count, w_coin_count;
    logic [1:0]          r_err_code,   w_err_code;
    logic                r_coin_valid, w_coin_valid;
    logic [2:0]          r_coin_code,  w_coin_code;
    logic [TO_W-1:0]     r_to_cnt,     w_to_cnt;
    logic [GAP_W-1:0]    r_gap_cnt,    w_gap_cnt;
    logic                r_done,       w_done;
    logic                r_busy,       w_busy;

    // Largest denomination not exceeding the balance (caller guarantees >= 25).
    function automatic logic [2:0] largest_code(input logic [AMOUNT_W-1:0] amt);
        int unsigned v;
        v = 32'(amt);
        if (v >= 32'd5000)      return 3'd6;
        else if (v >= 32'd2000) return 3'd5;
        else if (v >= 32'd1000) return 3'd4;
        else if (v >= 32'd500)  return 3'd3;
        else if (v >= 32'd100)  return 3'd2;
        else if (v >= 32'd50)   return 3'd1;
        else                    return 3'd0;
    endfunction

    function automatic logic [AMOUNT_W-1:0] coin_value(input logic [2:0] code);
        case (code)
            3'd0:    return AMOUNT_W'(32'd25);
            3'd1:    return AMOUNT_W'(32'd50);
            3'd2:    return AMOUNT_W'(32'd100);
            3'd3:    return AMOUNT_W'(32'd500);
            3'd4:    return AMOUNT_W'(32'd1000);
            3'd5:    return AMOUNT_W'(32'd2000);
            3'd6:    return AMOUNT_W'(32'd5000);
            default: return '0;
        endcase
    endfunction

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= c_IDLE;
            r_remaining  <= '0;
            r_coin_count <= '0;
            r_err_code   <= 2'b00;
            r_coin_valid <= 1'b0;
            r_coin_code  <= 3'd0;
            r_to_cnt     <= '0;
            r_gap_cnt    <= '0;
            r_done       <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_remaining  <= w_remaining;
            r_coin_count <= w_coin_count;
            r_err_code   <= w_err_code;
            r_coin_valid <= w_coin_valid;
            r_coin_code  <= w_coin_code;
            r_to_cnt     <= w_to_cnt;
            r_gap_cnt    <= w_gap_cnt;
            r_done       <= w_done;
            r_busy       <= w_busy;
        end
    end

    always_comb begin
        w_state      = r_state;
        w_remaining  = r_remaining;
        w_coin_count = r_coin_count;
        w_err_code   = r_err_code;
        w_coin_valid = r_coin_valid;
        w_coin_code  = r_coin_code;
        w_to_cnt     = r_to_cnt;
        w_gap_cnt    = r_gap_cnt;

        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_remaining  = amount;
                    w_coin_count = '0;
                    w_err_code   = 2'b00;
                    w_state      = c_SELECT;
                end
            end
            c_SELECT: begin
                if (r_remaining == '0) begin
                    w_state = c_DONE;
                end else if (32'(r_remaining) < 32'd25) begin
                    w_err_code = 2'b01;
                    w_state    = c_ERROR;
                end else begin
                    w_coin_code  = largest_code(r_remaining);
                    w_coin_valid = 1'b1;
                    w_to_cnt     = '0;
                    w_state      = c_ISSUE;
                end
            end
            c_ISSUE: begin
                // Ack is checked first so it wins over a timeout on the same edge.
                if (coin_ack) begin
                    w_remaining  = r_remaining - coin_value(r_coin_code);
                    w_coin_count = (r_coin_count == 5'd31) ? 5'd31 : r_coin_count + 5'd1;
                    w_coin_valid = 1'b0;
                    w_gap_cnt    = '0;
                    w_state      = (GAP_CYCLES == 0) ? c_SELECT : c_GAP;
                end else if (r_to_cnt == c_TO_LAST) begin
                    w_coin_valid = 1'b0;
                    w_err_code   = 2'b10;
                    w_state      = c_ERROR;
                end else begin
                    w_to_cnt = r_to_cnt + TO_W'(1);
                end
            end
            c_GAP: begin
                if (r_gap_cnt == c_GAP_LAST) begin
                    w_state = c_SELECT;
                end else begin
                    w_gap_cnt = r_gap_cnt + GAP_W'(1);
                end
            end
            c_DONE, c_ERROR: begin
                w_state = c_IDLE;
            end
            default: begin
                w_state = c_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        w_done = (w_state == c_DONE) || (w_state == c_ERROR);
        w_busy = (w_state != c_IDLE);
    end

    assign coin_valid = r_coin_valid;
    assign coin_code  = r_coin_code;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err_code   = r_err_code;
    assign coin_count = r_coin_count;
    assign remaining  = r_remaining;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_change_dispenser                                          |
// | Description : Directed self-checking bench for change_dispenser. Instance  |
// |               0 uses a 4-cycle gap, instance 1 no gap; both use a 16-cycle |
// |               ack timeout.                                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_change_dispenser;

    localparam int c_GAP = 4;
    localparam int c_TO  = 16;

    logic        clock;
    logic        rst_n      [2];
    logic        st         [2];
    logic [13:0] amt        [2];
    logic        ack        [2];
    logic        valid      [2];
    logic [2:0]  code       [2];
    logic        busy       [2];
    logic        done       [2];
    logic [1:0]  err        [2];
    logic [4:0]  cnt        [2];
    logic [13:0] rem        [2];

    int n_checks = 0;
    int n_errors = 0;

    change_dispenser #(
        .AMOUNT_W(14), .GAP_CYCLES(c_GAP), .ACK_TIMEOUT(c_TO), .TO_W(20)
    ) u_dut_gap (
        .clock(clock), .reset_n(rst_n[0]), .start(st[0]), .amount(amt[0]),
        .coin_ack(ack[0]), .coin_valid(valid[0]), .coin_code(code[0]),
        .busy(busy[0]), .done(done[0]), .err_code(err[0]),
        .coin_count(cnt[0]), .remaining(rem[0])
    );

    change_dispenser #(
        .AMOUNT_W(14), .GAP_CYCLES(0), .ACK_TIMEOUT(c_TO), .TO_W(20)
    ) u_dut_nogap (
        .clock(clock), .reset_n(rst_n[1]), .start(st[1]), .amount(amt[1]),
        .coin_ack(ack[1]), .coin_valid(valid[1]), .coin_code(code[1]),
        .busy(busy[1]), .done(done[1]), .err_code(err[1]),
        .coin_count(cnt[1]), .remaining(rem[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs one job on instance d. codes holds the expected coin sequence,
    // coin i in bits [3i+:3]. Each coin is acked after it has been offered for
    // ack_delay+1 cycles.
    task automatic run_job(input int d, input logic [13:0] a, input int n,
                           input logic [20:0] codes, input int ack_delay);
        int waited;
        int low;
        int dn;
        amt[d] = a;
        st[d]  = 1'b1;
        @(negedge clock);
        st[d]  = 1'b0;
        check("busy_after_start", busy[d], 1);
        for (int i = 0; i < n; i++) begin
            waited = 0;
            while (!valid[d] && waited < 40) begin
                @(negedge clock);
                waited++;
            end
            check("coin_valid_seen", valid[d], 1);
            check("coin_code", code[d], codes[3*i +: 3]);
            repeat (ack_delay) begin
                @(negedge clock);
                check("coin_stable", {valid[d], code[d]}, {1'b1, codes[3*i +: 3]});
            end
            ack[d] = 1'b1;
            @(negedge clock);
            ack[d] = 1'b0;
            check("valid_drop_after_ack", valid[d], 0);
            if (i < n - 1) begin
                low = 0;
                while (!valid[d] && low < 40) begin
                    low++;
                    @(negedge clock);
                end
                // gap cycles plus the one SELECT cycle
                check("valid_low_cycles", low, (d == 0) ? c_GAP + 1 : 1);
            end
        end
        dn = 0;
        repeat (12) begin
            dn += int'(done[d]);
            @(negedge clock);
        end
        check("done_pulses", dn, 1);
        check("busy_end", busy[d], 0);
    endtask

    initial begin
        int waited;
        int hi;
        int dn;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0;
            st[d]    = 1'b0;
            amt[d]   = '0;
            ack[d]   = 1'b0;
        end
        repeat (2) @(negedge clock);
        check("rst_outputs", {valid[0], code[0], busy[0], done[0], err[0], cnt[0]}, 0);
        check("rst_remaining", rem[0], 0);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;
        @(negedge clock);

        // 8675 with no gap: every denomination once, largest first.
        run_job(1, 14'd8675, 7, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6}, 0);
        check("t1_count", cnt[1], 7);
        check("t1_remaining", rem[1], 0);
        check("t1_err", err[1], 0);

        // 4000 with slow ack: two 2000 notes separated by the gap.
        run_job(0, 14'd4000, 2, 21'({3'd5, 3'd5}), 3);
        check("t2_count", cnt[0], 2);
        check("t2_remaining", rem[0], 0);
        check("t2_err", err[0], 0);

        // 130: 100 + 25, leaving an unpayable 5.
        run_job(0, 14'd130, 2, 21'({3'd0, 3'd2}), 1);
        check("t3_err", err[0], 1);
        check("t3_remaining", rem[0], 5);
        check("t3_count", cnt[0], 2);

        // 500 never acked: jam after 16 cycles of coin_valid.
        amt[0] = 14'd500;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        waited = 0;
        while (!valid[0] && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("t4_valid_seen", valid[0], 1);
        check("t4_code", code[0], 3);
        hi = 0;
        while (valid[0] && hi < 40) begin
            hi++;
            @(negedge clock);
        end
        check("t4_valid_high_cycles", hi, c_TO);
        check("t4_done", done[0], 1);
        check("t4_err", err[0], 2);
        check("t4_remaining", rem[0], 500);
        check("t4_count", cnt[0], 0);
        @(negedge clock);
        check("t4_done_one_cycle", done[0], 0);
        check("t4_idle", busy[0], 0);

        // Amount 0: done in the second cycle after the start edge, no coin.
        amt[0] = 14'd0;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        check("t5_done_cycle1", done[0], 0);
        check("t5_busy", busy[0], 1);
        @(negedge clock);
        check("t5_done_cycle2", done[0], 1);
        check("t5_no_coin", valid[0], 0);
        @(negedge clock);
        check("t5_done_off", done[0], 0);
        check("t5_idle", {busy[0], cnt[0], err[0]}, 0);
        check("t5_remaining", rem[0], 0);

        // 2000 job with start pulses while busy.
        amt[0] = 14'd2000;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        waited = 0;
        while (!valid[0] && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("t6_code", code[0], 5);
        amt[0] = 14'd25;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        check("t6_issue_ignore_rem", rem[0], 2000);
        check("t6_issue_ignore_coin", {valid[0], code[0]}, {1'b1, 3'd5});
        ack[0] = 1'b1;
        @(negedge clock);
        ack[0] = 1'b0;
        check("t6_rem_after_ack", rem[0], 0);
        amt[0] = 14'd100;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        dn = 0;
        hi = 0;
        repeat (12) begin
            dn += int'(done[0]);
            hi += int'(valid[0]);
            @(negedge clock);
        end
        check("t6_done_pulses", dn, 1);
        check("t6_no_extra_coin", hi, 0);
        check("t6_final", {busy[0], cnt[0], err[0]}, {1'b0, 5'd1, 2'd0});
        check("t6_remaining", rem[0], 0);

        // Reset in the middle of an 8675 job.
        amt[0] = 14'd8675;
        st[0]  = 1'b1;
        @(negedge clock);
        st[0]  = 1'b0;
        waited = 0;
        while (!valid[0] && waited < 40) begin
            @(negedge clock);
            waited++;
        end
        check("t7_in_issue", valid[0], 1);
        @(negedge clock);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("t7_async_outputs", {valid[0], code[0], busy[0], done[0], err[0], cnt[0]}, 0);
        check("t7_async_remaining", rem[0], 0);
        dn = 0;
        @(negedge clock);
        rst_n[0] = 1'b1;
        repeat (4) begin
            dn += int'(done[0]);
            @(negedge clock);
        end
        check("t7_no_done", dn, 0);
        run_job(0, 14'd25, 1, 21'd0, 0);
        check("t7_count", cnt[0], 1);
        check("t7_remaining", rem[0], 0);
        check("t7_err", err[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
